tdc_pair_sched: RTL

Pairing scheduler in front of the shared TDC difference datapath. It takes start-channel (A) and stop-channel (B) timestamp events from two TDC front-ends and enforces strict A-then-B ordering. It drops orphaned or timed-out events and replays each valid pair as two spaced `dval` strobes, in the exact order the difference unit expects, so that unit's internal pairing toggle can never desynchronise. It also tags each pair with the synchronised 10 kHz reference phase.

---
 rtl/tdc_pair_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tdc_pair_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_pair_sched
//  Purpose  : Pairs start (A) and stop (B) TDC timestamps in strict A-then-B
//             order, drops orphaned or timed-out events, and replays each pair
//             to the difference unit as two dval strobes separated by GAP idle
//             cycles. Each pair is tagged with the synchronised reference phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tdc_pair_sched #(
    parameter int W       = 37,
    parameter int TIMEOUT = 5000,
    parameter int GAP     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    input  logic [W-1:0] a_ts,
    input  logic         b_valid,
    input  logic [W-1:0] b_ts,
    input  logic         ref_in,
    output logic [W-1:0] pair_mlt,
    output logic         pair_dval,
    output logic         pair_phase,
    output logic         err_timeout,
    output logic         err_order,
    output logic [15:0]  pair_cnt,
    output logic         busy
);

    // Wait counter is 16 bits unless TIMEOUT needs more.
    localparam int c_CNT_W = (TIMEOUT < 65536) ? 16 : $clog2(TIMEOUT);
    // Sequencer counter covers both the GAP and the 3-cycle cool-down.
    localparam int c_SEQ_W = $clog2(GAP + 4);

    // The counter reads 0 in the first WAIT_B cycle, so it holds
    // (cycles since A capture - 1). Deciding at TIMEOUT-2 places the
    // registered timeout pulse exactly TIMEOUT cycles after capture.
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT - 2);
    localparam logic [c_SEQ_W-1:0] c_GAP_LAST  = c_SEQ_W'(GAP - 1);
    localparam logic [c_SEQ_W-1:0] c_COOL_LAST = c_SEQ_W'(2);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_B   = 3'd1,
        S_SEND_A   = 3'd2,
        S_GAP_WAIT = 3'd3,
        S_SEND_B   = 3'd4,
        S_COOL     = 3'd5
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_SEQ_W-1:0] r_seq;
    logic               r_ref_s1;
    logic               r_ref_s2;

    // Two-flop synchroniser for the asynchronous 10 kHz reference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
        end else begin
            r_ref_s1 <= ref_in;
            r_ref_s2 <= r_ref_s1;
        end
    end

    // Pairing FSM; every output is registered and set on the transition
    // into the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_seq       <= '0;
            pair_mlt    <= '0;
            pair_dval   <= 1'b0;
            pair_phase  <= 1'b0;
            err_timeout <= 1'b0;
            err_order   <= 1'b0;
            pair_cnt    <= 16'd0;
            busy        <= 1'b0;
        end else begin
            pair_dval   <= 1'b0;
            err_timeout <= 1'b0;
            err_order   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (a_valid && b_valid) begin
                        r_a        <= a_ts;
                        r_b        <= b_ts;
                        pair_phase <= r_ref_s2;
                        pair_mlt   <= a_ts;
                        pair_dval  <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_SEND_A;
                    end else if (a_valid) begin
                        r_a        <= a_ts;
                        pair_phase <= r_ref_s2;
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_WAIT_B;
                    end else if (b_valid) begin
                        // Stop with no start: discard.
                        err_order  <= 1'b1;
                    end
                end

                S_WAIT_B: begin
                    if (b_valid) begin
                        // A stop wins over a same-cycle timeout; a colliding
                        // start is discarded so the pending A is kept.
                        r_b        <= b_ts;
                        pair_mlt   <= r_a;
                        pair_dval  <= 1'b1;
                        err_order  <= a_valid;
                        r_state    <= S_SEND_A;
                    end else if (a_valid) begin
                        // Second start before a stop: newest start replaces it.
                        r_a        <= a_ts;
                        pair_phase <= r_ref_s2;
                        r_cnt      <= '0;
                        err_order  <= 1'b1;
                    end else if (r_cnt == c_TO_LAST) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_SEND_A: begin
                    r_seq   <= '0;
                    r_state <= S_GAP_WAIT;
                end

                S_GAP_WAIT: begin
                    if (r_seq == c_GAP_LAST) begin
                        pair_mlt  <= r_b;
                        pair_dval <= 1'b1;
                        pair_cnt  <= pair_cnt + 16'd1;
                        r_state   <= S_SEND_B;
                    end else begin
                        r_seq <= r_seq + c_SEQ_W'(1);
                    end
                end

                S_SEND_B: begin
                    r_seq   <= '0;
                    r_state <= S_COOL;
                end

                S_COOL: begin
                    // Let the downstream subtract/valid pipeline drain.
                    if (r_seq == c_COOL_LAST) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_seq <= r_seq + c_SEQ_W'(1);
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
